// File: rtl/flash_playback_scheduler.sv
// -----------------------------------------------------------------------------
// flash_playback_scheduler
//
// Streams audio from the 32-bit flash to the audio codec write FIFO.
// A fetch FSM keeps a small prefetch FIFO topped up with sample-pair words
// read over an Avalon-MM read port. A play FSM pops one word per pair, splits
// it into 16-bit signed samples, applies the volume shift and the playback-rate
// mode, and drives the codec write_s/write_ready handshake.
//
// Ports
//   clk                      in   1       system clock
//   resetb                   in   1       asynchronous active-low reset
//   mode                     in   2       00 normal, 01 fast, 10 slow, 11 normal
//   pause                    in   1       level, 1 holds playback between writes
//   flash_mem_read           out  1       Avalon read request
//   flash_mem_address        out  ADDR_W  Avalon word address
//   flash_mem_waitrequest    in   1       Avalon stall
//   flash_mem_readdata       in   32      {high sample, low sample}
//   flash_mem_readdatavalid  in   1       read data strobe
//   write_ready              in   1       codec FIFO can accept a sample
//   write_s                  out  1       codec write strobe
//   writedata                out  16      attenuated signed sample
//   wrap_pulse               out  1       one-cycle pulse when the address wraps
// -----------------------------------------------------------------------------
module flash_playback_scheduler #(
    parameter int unsigned       ADDR_W     = 23,
    parameter logic [ADDR_W-1:0] LAST_ADDR  = 23'h0FFFFF,
    parameter int unsigned       FIFO_DEPTH = 4,
    parameter int unsigned       VOL_SHIFT  = 6
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic [1:0]        mode,
    input  logic              pause,
    output logic              flash_mem_read,
    output logic [ADDR_W-1:0] flash_mem_address,
    input  logic              flash_mem_waitrequest,
    input  logic [31:0]       flash_mem_readdata,
    input  logic              flash_mem_readdatavalid,
    input  logic              write_ready,
    output logic              write_s,
    output logic [15:0]       writedata,
    output logic              wrap_pulse
);

    localparam int unsigned     PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned     CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {F_IDLE, F_REQ, F_WAIT} fetch_state_e;
    typedef enum logic [1:0] {P_LOAD, P_WAIT_READY, P_SEND, P_ACCEPT} play_state_e;
    typedef enum logic [1:0] {M_NORMAL = 2'b00, M_FAST = 2'b01, M_SLOW = 2'b10} play_mode_e;

    // -------------------------------------------------------------------------
    // Fetch FSM: one outstanding read at a time, issued whenever the FIFO has
    // room. The read strobe, address and wrap pulse are all registered.
    // -------------------------------------------------------------------------
    fetch_state_e      fetch_state_q;
    logic              read_q;
    logic [ADDR_W-1:0] addr_q;
    logic              wrap_q;
    logic [CNT_W-1:0]  fifo_count_q;
    logic [CNT_W-1:0]  fifo_count_d;
    logic              push;
    logic              pop;

    // Data is accepted only while a read is outstanding; stray strobes
    // (for instance from a read cut short by reset) fall through.
    assign push = (fetch_state_q == F_WAIT) && flash_mem_readdatavalid;

    // NOTE: sequential state uses non-blocking assignments so every register
    // in the block updates from the values present before the clock edge.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            fetch_state_q <= F_IDLE;
            read_q        <= 1'b0;
            addr_q        <= '0;
            wrap_q        <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            case (fetch_state_q)
                F_IDLE: begin
                    if (fifo_count_q < DEPTH_C) begin
                        fetch_state_q <= F_REQ;
                        read_q        <= 1'b1;
                    end
                end
                F_REQ: begin
                    if (!flash_mem_waitrequest) begin
                        fetch_state_q <= F_WAIT;
                        read_q        <= 1'b0;
                    end
                end
                F_WAIT: begin
                    if (flash_mem_readdatavalid) begin
                        fetch_state_q <= F_IDLE;
                        if (addr_q == LAST_ADDR) begin
                            addr_q <= '0;
                            wrap_q <= 1'b1;
                        end else begin
                            addr_q <= addr_q + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                    fetch_state_q <= F_IDLE;
                    read_q        <= 1'b0;
                end
            endcase
        end
    end

    assign flash_mem_read    = read_q;
    assign flash_mem_address = addr_q;
    assign wrap_pulse        = wrap_q;

    // -------------------------------------------------------------------------
    // Prefetch FIFO. The fetch FSM only requests while count < depth and only
    // one read is ever in flight, so a push can never meet a full FIFO.
    // -------------------------------------------------------------------------
    logic [31:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;

    // NOTE: the storage array has no reset; the pointers and count alone say
    // which entries are valid, so resetting the data would buy nothing.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= flash_mem_readdata;
        end
    end

    // NOTE: every signal written in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        fifo_count_d = fifo_count_q;
        if (push && !pop) begin
            fifo_count_d = fifo_count_q + CNT_W'(1);
        end else if (pop && !push) begin
            fifo_count_d = fifo_count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            fifo_count_q <= fifo_count_d;
        end
    end

    // -------------------------------------------------------------------------
    // Play FSM. Mode is latched with the pair so a mid-pair change only takes
    // effect on the next word. idx_q counts samples emitted from the pair.
    // -------------------------------------------------------------------------
    play_state_e        play_state_q;
    play_mode_e         mode_q;
    logic [31:0]        pair_q;
    logic [1:0]         idx_q;
    logic               write_s_q;
    logic [15:0]        wdata_q;
    logic signed [15:0] sample;
    logic signed [15:0] sample_scaled;
    logic               last_sample;

    assign pop = (play_state_q == P_LOAD) && (fifo_count_q != '0);

    function automatic play_mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'b01:   return M_FAST;
            2'b10:   return M_SLOW;
            default: return M_NORMAL;
        endcase
    endfunction

    // Sample order per pair: normal low,high; fast low; slow low,low,high,high.
    always_comb begin
        sample      = pair_q[15:0];
        last_sample = 1'b0;
        case (mode_q)
            M_FAST: begin
                sample      = pair_q[15:0];
                last_sample = 1'b1;
            end
            M_SLOW: begin
                sample      = idx_q[1] ? pair_q[31:16] : pair_q[15:0];
                last_sample = (idx_q == 2'd3);
            end
            default: begin
                sample      = idx_q[0] ? pair_q[31:16] : pair_q[15:0];
                last_sample = (idx_q == 2'd1);
            end
        endcase
    end

    // Arithmetic shift keeps the sign: -1 stays -1, -32768 becomes -512.
    assign sample_scaled = sample >>> VOL_SHIFT;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            play_state_q <= P_LOAD;
            mode_q       <= M_NORMAL;
            pair_q       <= '0;
            idx_q        <= '0;
            write_s_q    <= 1'b0;
            wdata_q      <= '0;
        end else begin
            case (play_state_q)
                P_LOAD: begin
                    // An empty FIFO is a plain underrun: simply wait.
                    if (fifo_count_q != '0) begin
                        pair_q       <= fifo_mem[rd_ptr_q];
                        mode_q       <= decode_mode(mode);
                        idx_q        <= '0;
                        play_state_q <= P_WAIT_READY;
                    end
                end
                P_WAIT_READY: begin
                    if (write_ready && !pause) begin
                        write_s_q    <= 1'b1;
                        wdata_q      <= sample_scaled;
                        play_state_q <= P_SEND;
                    end
                end
                P_SEND: begin
                    play_state_q <= P_ACCEPT;
                end
                P_ACCEPT: begin
                    // The codec acknowledges by dropping write_ready; pause is
                    // deliberately ignored here so a started write completes.
                    if (!write_ready) begin
                        write_s_q <= 1'b0;
                        if (last_sample) begin
                            play_state_q <= P_LOAD;
                        end else begin
                            idx_q        <= idx_q + 2'd1;
                            play_state_q <= P_WAIT_READY;
                        end
                    end
                end
                default: begin
                    play_state_q <= P_LOAD;
                    write_s_q    <= 1'b0;
                end
            endcase
        end
    end

    assign write_s   = write_s_q;
    assign writedata = wdata_q;

endmodule
